nios_accel_pio_in_edge: RTL
===========================

Name: nios_accel_pio_in_edge

Overview:
- Parametrised Avalon-MM input PIO that succeeds the single-bit accelerometer FIR output ports on the Nios accelerometer system bus.
- Samples a DATA_WIDTH-bit input bus through a synchroniser and detects edges per bit into a sticky edge-capture register.
- Drives a maskable level interrupt to the Nios CPU.
- Readdata is registered with one-cycle read latency, as on the existing PIO slaves.

Parameters:
- DATA_WIDTH, 8: input bus width, legal range 1..32.
- EDGE_TYPE, 0: edge to capture; 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2: synchroniser flops per bit, legal range 2..4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  DATA_WIDTH  asynchronous input bus.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset state: all flops clear, including sync chain, prev, edgecapture, irqmask, readdata and the valid counter. readdata = 0 and irq = 0 in the cycle after reset is sampled low.
- Synchroniser: in_port passes through SYNC_STAGES flops to give s. prev <= s every cycle.
- Priming: a valid counter counts from 0 to SYNC_STAGES+1 after reset, then saturates. Edge detection is suppressed until the counter saturates, so an input held static through reset never captures.
- Edge detect per bit (only once valid):
  - rise = s & ~prev
  - fall = ~s & prev
  - edge is selected by EDGE_TYPE (EDGE_TYPE = 2 uses rise | fall).
- Latency: a clean transition on in_port sets its edgecapture bit SYNC_STAGES+1 clocks later.
- Register map (reads):
  - addr 0: data = zero-extended s.
  - addr 1: 0, reserved.
  - addr 2: irqmask.
  - addr 3: edgecapture.
- Read timing: readdata <= mux(address) every cycle, so it is valid on the cycle after address is presented. Bits above DATA_WIDTH always read 0.
- Writes occur when chipselect = 1 and write_n = 0:
  - addr 2: irqmask <= writedata[DATA_WIDTH-1:0].
  - addr 3: write-1-to-clear per bit of edgecapture.
  - addr 0 and addr 1: writes are ignored.
- Simultaneous edge and clear on the same bit: set wins, and the bit remains 1.
- irq = |(edgecapture & irqmask). It is combinational from registers, so it rises in the same cycle the capture bit sets.
- Reset asserted mid-operation: all state is cleared on the next edge of clk and priming restarts.
- Unknown address values cannot occur (2-bit address); all four decodes are defined above.

Optional Feature:
- Macro: NIOS_ACCEL_PIO_IRQ_EN.
- Defined: irqmask register and irq logic are present as specified above.
- Undefined:
  - irqmask is not implemented; addr 2 reads 0 and writes to it are ignored.
  - irq is tied to 0.
  - edgecapture remains fully functional for polling.

Decomposition:
- Shared package nios_accel_pkg holds:
  - address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_IRQMASK=2, ADDR_EDGE=3;
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings;
  - the AVALON_DATA_W=32 constant.
- One sub-module, nios_accel_sync_edge: a per-bus synchroniser plus prev register plus edge select, parametrised by width, stages and edge type. The top level holds the register file, priming counter and read mux.

Test Plan (DATA_WIDTH=8, SYNC_STAGES=2):
- Reset with in_port=8'hFF held, then release → no capture; read addr 3 gives 0; read addr 0 gives 32'h000000FF.
- EDGE_TYPE=0, in_port 8'h00→8'h05 at cycle t → edgecapture=8'h05 at t+3; read addr 3 gives 32'h00000005 one cycle after address is presented.
- irqmask=8'h04, then edge on bit 2 → irq=1; write 32'h4 to addr 3 → edgecapture=0 and irq=0 next cycle. Edge on bit 0 only → irq stays 0.
- Write 32'h1 to addr 3 in the same cycle bit 0 detects a new edge → bit 0 remains 1.
- EDGE_TYPE=2, bit 7 pulses high for 4 cycles → captured at the rise; clear the bit; the fall then recaptures it.
- reset_n low for 1 cycle with edgecapture=8'hFF and irq=1 → all registers 0 and irq=0 next cycle. Build without NIOS_ACCEL_PIO_IRQ_EN → addr 2 reads 0 and irq stays 0 throughout.

Source files
------------

// File: rtl/nios_accel_pio_in_edge_pkg.sv
// rtl/nios_accel_pio_in_edge_pkg.sv - shared constants for the accelerometer input PIO
package nios_accel_pkg;

    localparam int AVALON_DATA_W = 32;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGE    = 2'd3
    } reg_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_accel_pio_in_edge_if.sv
// rtl/nios_accel_pio_in_edge_if.sv - Avalon-MM slave bus for the input PIO
interface nios_accel_pio_in_edge_if;
    import nios_accel_pkg::*;

    logic [1:0]               address;
    logic                     chipselect;
    logic                     write_n;
    logic [AVALON_DATA_W-1:0] writedata;
    logic [AVALON_DATA_W-1:0] readdata;
    logic                     irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/nios_accel_pio_in_edge_sync_edge.sv
// rtl/nios_accel_pio_in_edge_sync_edge.sv - per-bus synchroniser, prev register and edge select
module nios_accel_sync_edge
    import nios_accel_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 2,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_bus,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] edges
);

    logic [STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]             prev;
    logic [WIDTH-1:0]             rise;
    logic [WIDTH-1:0]             fall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= '0;
            prev  <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], in_bus};
            prev  <= chain[STAGES-1];
        end
    end

    assign data = chain[STAGES-1];
    assign rise = data & ~prev;
    assign fall = ~data & prev;

    always_comb begin
        edges = rise | fall;
        case (EDGE_TYPE)
            EDGE_RISE: edges = rise;
            EDGE_FALL: edges = fall;
            default:   edges = rise | fall;
        endcase
    end

endmodule

// File: rtl/nios_accel_pio_in_edge.sv
// rtl/nios_accel_pio_in_edge.sv - edge-capturing input PIO; NIOS_ACCEL_PIO_IRQ_EN adds irqmask and irq
module nios_accel_pio_in_edge
    import nios_accel_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios_accel_pio_in_edge_if.slave bus,
    input  logic [DATA_WIDTH-1:0] in_port
);

    localparam int                CNT_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] edges;
    logic [DATA_WIDTH-1:0] edgecapture;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] clr;
    logic [CNT_W-1:0]      valid_cnt;
    logic                  valid;
    logic                  write_en;
    logic [AVALON_DATA_W-1:0] rd_next;
    logic                  unused_wd;

    nios_accel_sync_edge #(
        .WIDTH     (DATA_WIDTH),
        .STAGES    (SYNC_STAGES),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_bus  (in_port),
        .data    (data),
        .edges   (edges)
    );

    assign write_en  = bus.chipselect & ~bus.write_n;
    assign valid     = (valid_cnt == CNT_MAX);
    assign clr       = (write_en && bus.address == ADDR_EDGE) ? bus.writedata[DATA_WIDTH-1:0] : '0;
    assign unused_wd = |(bus.writedata >> DATA_WIDTH);

    // Priming hides the sync chain filling after reset so a static input never captures.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_cnt   <= '0;
            edgecapture <= '0;
        end else begin
            if (!valid) valid_cnt <= valid_cnt + 1'b1;
            edgecapture <= (edgecapture & ~clr) | (valid ? edges : '0);
        end
    end

`ifdef NIOS_ACCEL_PIO_IRQ_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (write_en && bus.address == ADDR_IRQMASK) begin
            irqmask <= bus.writedata[DATA_WIDTH-1:0];
        end
    end

    assign bus.irq = |(edgecapture & irqmask);
`else
    assign irqmask = '0;
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        rd_next = '0;
        case (reg_addr_e'(bus.address))
            ADDR_DATA:    rd_next = AVALON_DATA_W'(data);
            ADDR_RSVD:    rd_next = '0;
            ADDR_IRQMASK: rd_next = AVALON_DATA_W'(irqmask);
            ADDR_EDGE:    rd_next = AVALON_DATA_W'(edgecapture);
            default:      rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_next;
    end

endmodule
